// File: rtl/csr_uart_fifo_pkg.sv
// Shared definitions for the buffered CSR UART: CSR modify codes, status word
// bit positions and the receiver/transmitter state encodings.
package csr_uart_fifo_pkg;

  localparam logic [2:0] MOD_WRITE = 3'b001;
  localparam logic [2:0] MOD_SET   = 3'b010;
  localparam logic [2:0] MOD_CLEAR = 3'b011;

  localparam int ST_RX_EMPTY  = 8;
  localparam int ST_TX_FULL   = 9;
  localparam int ST_OVERRUN   = 10;
  localparam int ST_FRAME_ERR = 11;
  localparam int ST_RX_COUNT  = 12;
  localparam int ST_TX_COUNT  = 16;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_t;

endpackage

// File: rtl/csr_sync_fifo.sv
// Byte-wide synchronous FIFO. A push is accepted when not full, or when a pop
// happens in the same cycle; pop on empty is ignored; flush overrides both.
module csr_sync_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [7:0]            din,
  output logic [7:0]            head,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (DEPTH_LOG2+1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/csr_uart_fifo.sv
// Buffered 8N1 UART on the CSR bus: one data/status register at BASE_ADDR,
// TX and RX character FIFOs, sticky overrun and framing-error flags.
module csr_uart_fifo
  import csr_uart_fifo_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR  = 12'hbc3,
  parameter int          CLOCK_RATE = 12_000_000,
  parameter int          BAUD_RATE  = 115200,
  parameter int          DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        read,
  input  logic [2:0]  modify,
  input  logic [31:0] wdata,
  input  logic [11:0] addr,
  output logic [31:0] rdata,
  output logic        valid,
  input  logic        rx,
  output logic        tx,
  output logic        AVOID_WARNING
);

  localparam logic [15:0] CLOCK_DIV = 16'(CLOCK_RATE / BAUD_RATE);
  localparam logic [15:0] HALF_DIV  = CLOCK_DIV >> 1;
  localparam int          CW        = DEPTH_LOG2 + 1;

  logic          en;
  logic [31:0]   status;
  logic          is_write, is_set, is_clear;
  logic          rx_push, rx_pop, rx_flush, rx_accept;
  logic          tx_push, tx_pop, tx_flush;
  logic [7:0]    rx_head, tx_head;
  logic [CW-1:0] rx_count, tx_count;
  logic          rx_empty, rx_full, tx_empty, tx_full;
  logic          overrun, frame_err;
  logic          unused_wdata;

  assign AVOID_WARNING = read;
  assign unused_wdata  = ^wdata[31:8];

  assign is_write = en && (modify == MOD_WRITE);
  assign is_set   = en && (modify == MOD_SET);
  assign is_clear = en && (modify == MOD_CLEAR);
  assign tx_push  = is_write;
  assign rx_pop   = is_set && wdata[0];
  assign rx_flush = is_clear && wdata[0];
  assign tx_flush = is_clear && wdata[1];

  always_comb begin
    status                      = '0;
    status[7:0]                 = rx_empty ? 8'h00 : rx_head;
    status[ST_RX_EMPTY]         = rx_empty;
    status[ST_TX_FULL]          = tx_full;
    status[ST_OVERRUN]          = overrun;
    status[ST_FRAME_ERR]        = frame_err;
    status[ST_RX_COUNT +: 4]    = 4'(rx_count);
    status[ST_TX_COUNT +: 4]    = 4'(tx_count);
  end

  // rdata reflects the state seen during the E stage, before that cycle's op lands.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      en    <= 1'b0;
      valid <= 1'b0;
      rdata <= '0;
    end else begin
      en    <= (addr == BASE_ADDR);
      valid <= en;
      rdata <= en ? status : '0;
    end
  end

  // ---------------- receiver ----------------
  rx_state_t   rx_state;
  logic [1:0]  rx_sync;
  logic        rx_s;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_sample;

  assign rx_s      = rx_sync[1];
  assign rx_sample = (rx_cnt == '0);
  assign rx_push   = (rx_state == RX_STOP) && rx_sample && rx_s;
  assign rx_accept = !rx_full || (rx_pop && !rx_empty);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_sync   <= 2'b11;
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], rx};
      if (is_set && wdata[1]) overrun   <= 1'b0;
      if (is_set && wdata[2]) frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_s) begin
            rx_state <= RX_START;
            rx_cnt   <= HALF_DIV;
          end
        end
        RX_START: begin
          if (rx_sample) begin
            if (rx_s) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_DATA;
              rx_cnt   <= CLOCK_DIV - 16'd1;
              rx_bit   <= '0;
            end
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_sample) begin
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_cnt   <= CLOCK_DIV - 16'd1;
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_sample) begin
            // Flag updates sit after the clears so a same-cycle event wins.
            if (rx_s) begin
              if (!rx_accept) overrun <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- transmitter ----------------
  tx_state_t   tx_state;
  logic [9:0]  tx_shift;
  logic [15:0] tx_cnt;
  logic [3:0]  tx_bit;

  assign tx     = tx_shift[0];
  assign tx_pop = (tx_state == TX_IDLE) && !tx_empty;

  // Shifting in ones leaves the line high once the stop bit has gone out.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_state <= TX_IDLE;
      tx_shift <= '1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (!tx_empty) begin
            tx_shift <= {1'b1, tx_head, 1'b0};
            tx_cnt   <= CLOCK_DIV - 16'd1;
            tx_bit   <= '0;
            tx_state <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (tx_cnt == '0) begin
            if (tx_bit == 4'd9) begin
              tx_state <= TX_IDLE;
            end else begin
              tx_shift <= {1'b1, tx_shift[9:1]};
              tx_bit   <= tx_bit + 4'd1;
              tx_cnt   <= CLOCK_DIV - 16'd1;
            end
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  csr_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (rx_flush),
    .din   (rx_shift),
    .head  (rx_head),
    .count (rx_count),
    .empty (rx_empty),
    .full  (rx_full)
  );

  csr_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (tx_flush),
    .din   (wdata[7:0]),
    .head  (tx_head),
    .count (tx_count),
    .empty (tx_empty),
    .full  (tx_full)
  );

endmodule
